// File: rtl/fwd_source_pipe.sv
// Producer side of operand forwarding: EX/MEM and MEM/WB registers, MEM-stage
// data-memory handshake with bounded wait, and load-use / memory-wait stalls.
module fwd_source_pipe #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ex_wreg,
  input  logic [15:0] ex_result,
  input  logic [1:0]  ex_mem_control,
  input  logic [15:0] ex_store_data,
  input  logic [3:0]  id_r1,
  input  logic [3:0]  id_r2,
  input  logic        flush,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [3:0]  wreg_fw1,
  output logic [15:0] fw1_data,
  output logic [3:0]  wreg_fw2,
  output logic [15:0] fw2_data,
  output logic        stall_id,
  output logic        stall_mem,
  output logic        mem_timeout
);

  localparam logic [3:0] NOREG = 4'hF;
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic {M_IDLE, M_WAIT} mstate_e;

  mstate_e        state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     wreg1_q, wreg1_d, wreg2_q, wreg2_d;
  logic [15:0]    data1_q, data1_d, sdata1_q, sdata1_d, data2_q, data2_d;
  logic [1:0]     ctl1_q, ctl1_d;
  logic           pflush_q, pflush_d, tout_q, tout_d;
  logic           is_load, is_store, force_c, load_use;

  assign is_load   = (ctl1_q == 2'b01);
  assign is_store  = (ctl1_q == 2'b10);
  assign force_c   = (state_q == M_WAIT) && (cnt_q == CW'(WAIT_LIMIT));
  assign mem_req   = is_load || is_store;
  assign mem_we    = is_store;
  assign mem_addr  = data1_q;
  assign mem_wdata = sdata1_q;
  assign stall_mem = mem_req && !mem_ready && !force_c;

  assign load_use  = (ex_mem_control == 2'b01) && (ex_wreg != NOREG) &&
                     ((ex_wreg == id_r1) || (ex_wreg == id_r2));
  assign stall_id  = stall_mem || load_use;

  // Load data is not valid until MEM/WB, so loads are hidden from stage 1.
  assign wreg_fw1    = mem_req ? NOREG : wreg1_q;
  assign fw1_data    = data1_q;
  assign wreg_fw2    = wreg2_q;
  assign fw2_data    = data2_q;
  assign mem_timeout = tout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      M_IDLE: if (stall_mem) begin
        state_d = M_WAIT;
        cnt_d   = '0;
      end
      M_WAIT: if (mem_ready || force_c) begin
        state_d = M_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = M_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wreg1_d  = wreg1_q;
    data1_d  = data1_q;
    ctl1_d   = ctl1_q;
    sdata1_d = sdata1_q;
    pflush_d = pflush_q;
    wreg2_d  = NOREG;
    data2_d  = '0;
    tout_d   = tout_q || force_c;
    if (stall_mem) begin
      // A flush seen while EX/MEM is frozen is remembered for the next capture.
      pflush_d = pflush_q || flush;
    end else begin
      pflush_d = 1'b0;
      if (flush || pflush_q) begin
        wreg1_d  = NOREG;
        data1_d  = '0;
        ctl1_d   = 2'b00;
        sdata1_d = '0;
      end else begin
        wreg1_d  = ex_wreg;
        data1_d  = ex_result;
        ctl1_d   = ex_mem_control;
        sdata1_d = ex_store_data;
      end
      wreg2_d = is_store ? NOREG : wreg1_q;
      data2_d = is_load ? (force_c ? 16'h0000 : mem_rdata) : data1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= M_IDLE;
      cnt_q    <= '0;
      wreg1_q  <= NOREG;
      data1_q  <= '0;
      ctl1_q   <= 2'b00;
      sdata1_q <= '0;
      wreg2_q  <= NOREG;
      data2_q  <= '0;
      pflush_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wreg1_q  <= wreg1_d;
      data1_q  <= data1_d;
      ctl1_q   <= ctl1_d;
      sdata1_q <= sdata1_d;
      wreg2_q  <= wreg2_d;
      data2_q  <= data2_d;
      pflush_q <= pflush_d;
      tout_q   <= tout_d;
    end
  end

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed scenarios plus randomized traffic against a transaction-level model
// of the forwarding source stages.
module tb_fwd_source_pipe;
  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ex_wreg, id_r1, id_r2;
  logic [15:0] ex_result, ex_store_data, mem_rdata;
  logic [1:0]  ex_mem_control;
  logic        flush, mem_ready;
  logic        mem_req, mem_we, stall_id, stall_mem, mem_timeout;
  logic [15:0] mem_addr, mem_wdata, fw1_data, fw2_data;
  logic [3:0]  wreg_fw1, wreg_fw2;

  int n_checks = 0;
  int n_fail   = 0;

  fwd_source_pipe #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst), .ex_wreg(ex_wreg), .ex_result(ex_result),
    .ex_mem_control(ex_mem_control), .ex_store_data(ex_store_data),
    .id_r1(id_r1), .id_r2(id_r2), .flush(flush), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wreg_fw1(wreg_fw1),
    .fw1_data(fw1_data), .wreg_fw2(wreg_fw2), .fw2_data(fw2_data),
    .stall_id(stall_id), .stall_mem(stall_mem), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Model: one slot per pipeline stage plus how long the current access has waited.
  typedef struct {
    logic [3:0]  wreg;
    logic [15:0] data;
    logic [1:0]  ctl;
    logic [15:0] sd;
  } slot_t;
  slot_t       m_em;
  logic [3:0]  m_wb_reg;
  logic [15:0] m_wb_data;
  logic        m_pend, m_tout;
  int          m_waited;

  task automatic m_reset();
    m_em = '{wreg: 4'hF, data: 16'h0, ctl: 2'b00, sd: 16'h0};
    m_wb_reg = 4'hF; m_wb_data = 16'h0;
    m_pend = 1'b0; m_tout = 1'b0; m_waited = 0;
  endtask

  function automatic bit m_access();
    return (m_em.ctl == 2'b01) || (m_em.ctl == 2'b10);
  endfunction

  function automatic bit m_forced();
    return m_access() && (m_waited == WL + 1);
  endfunction

  function automatic bit m_stall();
    return m_access() && !mem_ready && !m_forced();
  endfunction

  function automatic logic [76:0] m_expect();
    logic lu;
    lu = (ex_mem_control == 2'b01) && (ex_wreg != 4'hF) &&
         (ex_wreg == id_r1 || ex_wreg == id_r2);
    return {m_access(), m_em.ctl == 2'b10, m_em.data, m_em.sd,
            m_access() ? 4'hF : m_em.wreg, m_em.data, m_wb_reg, m_wb_data,
            m_stall() || lu, m_stall(), m_tout};
  endfunction

  task automatic m_update();
    if (m_stall()) begin
      m_wb_reg = 4'hF; m_wb_data = 16'h0;
      m_waited++;
      if (flush) m_pend = 1'b1;
    end else begin
      if (m_forced()) m_tout = 1'b1;
      m_wb_reg  = (m_em.ctl == 2'b10) ? 4'hF : m_em.wreg;
      m_wb_data = (m_em.ctl == 2'b01) ? (m_forced() ? 16'h0 : mem_rdata) : m_em.data;
      if (flush || m_pend) m_em = '{wreg: 4'hF, data: 16'h0, ctl: 2'b00, sd: 16'h0};
      else m_em = '{wreg: ex_wreg, data: ex_result, ctl: ex_mem_control, sd: ex_store_data};
      m_pend = 1'b0;
      m_waited = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) m_reset(); else m_update();
    @(negedge clk);
  endtask

  task automatic set_ex(input logic [3:0] w, input logic [1:0] c, input logic [15:0] r,
                        input logic [15:0] sd);
    ex_wreg = w; ex_mem_control = c; ex_result = r; ex_store_data = sd;
  endtask

  task automatic do_reset();
    set_ex(4'hF, 2'b00, 16'h0, 16'h0);
    id_r1 = 4'h0; id_r2 = 4'h0; flush = 1'b0; mem_rdata = 16'h0; mem_ready = 1'b1;
    rst = 1'b0; m_reset();
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({wreg_fw1, wreg_fw2, fw1_data, fw2_data, mem_req, mem_we, mem_addr, mem_wdata,
         stall_id, stall_mem, mem_timeout} !== {4'hF, 4'hF, 32'h0, 2'b00, 32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: fw1=%h fw2=%h d1=%h d2=%h req=%b we=%b stalls=%b%b to=%b",
               wreg_fw1, wreg_fw2, fw1_data, fw2_data, mem_req, mem_we, stall_id, stall_mem,
               mem_timeout);
    end
  endtask

  task automatic test_alu_chain();
    set_ex(4'd3, 2'b00, 16'h1234, 16'h0);
    tick(); #1;
    n_checks++;
    if ({wreg_fw1, fw1_data} !== {4'd3, 16'h1234}) begin
      n_fail++; $display("FAIL alu_stage1: got %h/%h want 3/1234", wreg_fw1, fw1_data);
    end
    set_ex(4'hF, 2'b00, 16'h0, 16'h0);
    tick(); #1;
    n_checks++;
    if ({wreg_fw2, fw2_data} !== {4'd3, 16'h1234}) begin
      n_fail++; $display("FAIL alu_stage2: got %h/%h want 3/1234", wreg_fw2, fw2_data);
    end
  endtask

  task automatic test_load_use();
    set_ex(4'd5, 2'b01, 16'h0040, 16'h0); id_r1 = 4'd0; id_r2 = 4'd5;
    #1;
    n_checks++;
    if (stall_id !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall: got %b want 1", stall_id);
    end
    tick();
    set_ex(4'hF, 2'b00, 16'h0, 16'h0); id_r2 = 4'd0;
    mem_rdata = 16'hBEEF; mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({wreg_fw1, mem_req, mem_addr, stall_mem} !== {4'hF, 1'b1, 16'h0040, 1'b0}) begin
      n_fail++;
      $display("FAIL load_mem_stage: fw1=%h req=%b addr=%h smem=%b want F/1/0040/0",
               wreg_fw1, mem_req, mem_addr, stall_mem);
    end
    tick(); #1;
    n_checks++;
    if ({wreg_fw2, fw2_data} !== {4'd5, 16'hBEEF}) begin
      n_fail++; $display("FAIL load_wb: got %h/%h want 5/BEEF", wreg_fw2, fw2_data);
    end
  endtask

  task automatic test_slow_store();
    set_ex(4'd9, 2'b10, 16'h0100, 16'hCAFE); mem_ready = 1'b0;
    tick();
    set_ex(4'd2, 2'b00, 16'h7777, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({stall_mem, stall_id, mem_addr, mem_we} !== {1'b1, 1'b1, 16'h0100, 1'b1} ||
          (i > 0 && wreg_fw2 !== 4'hF)) begin
        n_fail++;
        $display("FAIL store_wait[%0d]: smem=%b sid=%b addr=%h we=%b fw2=%h", i, stall_mem,
                 stall_id, mem_addr, mem_we, wreg_fw2);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({stall_mem, mem_we, mem_wdata} !== {1'b0, 1'b1, 16'hCAFE}) begin
      n_fail++;
      $display("FAIL store_done: smem=%b we=%b wdata=%h want 0/1/CAFE", stall_mem, mem_we,
               mem_wdata);
    end
    tick(); #1;
    n_checks++;
    if ({wreg_fw2, wreg_fw1, fw1_data} !== {4'hF, 4'd2, 16'h7777}) begin
      n_fail++;
      $display("FAIL store_after: fw2=%h fw1=%h d1=%h want F/2/7777", wreg_fw2, wreg_fw1,
               fw1_data);
    end
  endtask

  task automatic test_timeout();
    int stalled;
    set_ex(4'd6, 2'b01, 16'h0200, 16'h0); mem_ready = 1'b0; mem_rdata = 16'h5A5A;
    tick();
    set_ex(4'd1, 2'b00, 16'h0, 16'h0);
    stalled = 0;
    #1;
    while (stall_mem === 1'b1 && stalled < 40) begin
      stalled++;
      tick(); #1;
    end
    n_checks++;
    if (stalled != WL + 1 || mem_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_wait: stalled %0d cycles to=%b want %0d/0", stalled, mem_timeout,
               WL + 1);
    end
    tick(); #1;
    n_checks++;
    if ({mem_timeout, wreg_fw2, fw2_data} !== {1'b1, 4'd6, 16'h0}) begin
      n_fail++;
      $display("FAIL timeout_done: to=%b fw2=%h d2=%h want 1/6/0000", mem_timeout, wreg_fw2,
               fw2_data);
    end
    mem_ready = 1'b1;
    tick(); #1;
    n_checks++;
    if (mem_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
    end
  endtask

  task automatic test_flush_during_wait();
    set_ex(4'd4, 2'b01, 16'h0300, 16'h0); mem_ready = 1'b0; mem_rdata = 16'h0042;
    tick();
    set_ex(4'd7, 2'b00, 16'h1111, 16'h0); flush = 1'b1;
    #1;
    n_checks++;
    if (stall_mem !== 1'b1) begin
      n_fail++; $display("FAIL flush_wait_stall: got %b want 1", stall_mem);
    end
    tick();
    flush = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick(); #1;
    n_checks++;
    if ({wreg_fw1, wreg_fw2, fw2_data} !== {4'hF, 4'd4, 16'h0042}) begin
      n_fail++;
      $display("FAIL flush_bubble: fw1=%h fw2=%h d2=%h want F/4/0042", wreg_fw1, wreg_fw2,
               fw2_data);
    end
    tick(); #1;
    n_checks++;
    if (wreg_fw1 !== 4'd7) begin
      n_fail++; $display("FAIL flush_cleared: fw1=%h want 7", wreg_fw1);
    end
  endtask

  task automatic test_reset_mid();
    set_ex(4'd8, 2'b01, 16'h0400, 16'h0); mem_ready = 1'b0;
    tick();
    set_ex(4'hF, 2'b00, 16'h0, 16'h0);
    tick();
    rst = 1'b0; m_reset();
    #1;
    n_checks++;
    if ({wreg_fw1, wreg_fw2, mem_req, stall_mem, mem_timeout} !== {8'hFF, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid: fw1=%h fw2=%h req=%b smem=%b to=%b", wreg_fw1, wreg_fw2,
               mem_req, stall_mem, mem_timeout);
    end
    tick();
    rst = 1'b1; mem_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [76:0] exp_v, got_v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_ex(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom),
             16'($urandom));
      id_r1 = 4'($urandom_range(0, 15)); id_r2 = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 9) == 0);
      mem_rdata = 16'($urandom);
      if ((i / 60) % 3 == 2) mem_ready = ($urandom_range(0, 7) == 0);
      else mem_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_v = m_expect();
      got_v = {mem_req, mem_we, mem_addr, mem_wdata, wreg_fw1, fw1_data, wreg_fw2, fw2_data,
               stall_id, stall_mem, mem_timeout};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, got_v, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_slow_store();
    test_timeout();
    test_flush_during_wait();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
